// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the pipeline: word type, bubble encoding and
// the contents of the IF/ID pipeline register.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // addi x0,x0,0 -- architectural no-op used as the pipeline bubble
  localparam word_t RV32I_NOP = 32'h0000_0013;

  // Default PC loaded on reset
  localparam word_t DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Byte distance between sequential instructions
  localparam word_t INSTR_BYTES = 32'd4;

  // Contents of the IF/ID register as seen by decode
  typedef struct packed {
    word_t pc;
    word_t pc_plus_4;
    word_t instruction;
    logic  valid;
  } if_id_t;

  // Force an address onto a word boundary (drops the two low bits)
  function automatic word_t word_align(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Flush has priority over hold: a flush drops the
// captured instruction to a bubble but keeps the PC fields, a hold freezes
// every field, otherwise the fetched values are captured.
module if_id_register
  import rv32i_pkg::*;
#(
  parameter word_t NOP_INSTRUCTION = RV32I_NOP
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   hold,
  input  logic   flush,
  input  word_t  fetch_pc,
  input  word_t  fetch_pc_plus_4,
  input  word_t  fetch_instruction,
  output if_id_t stage
);

  // IF/ID flops: reset to bubble, flush to bubble, hold, or capture fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage.pc          <= '0;
      stage.pc_plus_4   <= '0;
      stage.instruction <= NOP_INSTRUCTION;
      stage.valid       <= 1'b0;
    end else if (flush) begin
      stage.instruction <= NOP_INSTRUCTION;
      stage.valid       <= 1'b0;
    end else if (!hold) begin
      stage.pc          <= fetch_pc;
      stage.pc_plus_4   <= fetch_pc_plus_4;
      stage.instruction <= fetch_instruction;
      stage.valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: program counter, next-PC selection, IF/ID register and
// saturating stall/flush event counters.
//
// Control semantics (checked every rising edge, in priority order):
//   EX_branch_taken = 1 : redirect; wins over stale, squashes IF/ID, counts a flush
//   stale           = 1 : freeze PC and IF/ID, counts a stall
//   otherwise           : advance PC by 4 and capture imem_data into IF/ID
// imem_address is the only combinational output (it is the PC register).
module instruction_fetch_stage
  import rv32i_pkg::*;
#(
  parameter word_t RESET_VECTOR    = DEFAULT_RESET_VECTOR,
  parameter word_t NOP_INSTRUCTION = RV32I_NOP,
  parameter int    COUNTER_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stale,
  input  logic                     EX_branch_taken,
  input  logic [31:0]              EX_branch_target,
  output logic [31:0]              imem_address,
  input  logic [31:0]              imem_data,
  output logic [31:0]              ID_pc,
  output logic [31:0]              ID_pc_plus_4,
  output logic [31:0]              ID_instruction,
  output logic                     ID_valid,
  output logic                     misaligned_target,
  output logic [COUNTER_WIDTH-1:0] stall_count,
  output logic [COUNTER_WIDTH-1:0] flush_count
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};

  word_t  pc;
  word_t  pc_plus_4;
  logic   redirect;
  logic   stall;
  if_id_t if_id;

  // Redirect overrides a stall request in the same cycle
  assign redirect  = EX_branch_taken;
  assign stall     = stale && !EX_branch_taken;
  assign pc_plus_4 = pc + INSTR_BYTES;

  // Program counter: redirect to aligned target, hold on stall, else step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else if (redirect) begin
      pc <= word_align(EX_branch_target);
    end else if (!stall) begin
      pc <= pc_plus_4;
    end
  end

  // Sticky misaligned-target flag; only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misaligned_target <= 1'b0;
    end else if (redirect && (EX_branch_target[1:0] != 2'b00)) begin
      misaligned_target <= 1'b1;
    end
  end

  // Saturating event counters for accepted stalls and redirects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != COUNT_MAX)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (redirect && (flush_count != COUNT_MAX)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  if_id_register #(
    .NOP_INSTRUCTION (NOP_INSTRUCTION)
  ) u_if_id (
    .clk               (clk),
    .reset_n           (reset_n),
    .hold              (stall),
    .flush             (redirect),
    .fetch_pc          (pc),
    .fetch_pc_plus_4   (pc_plus_4),
    .fetch_instruction (imem_data),
    .stage             (if_id)
  );

  assign imem_address   = pc;
  assign ID_pc          = if_id.pc;
  assign ID_pc_plus_4   = if_id.pc_plus_4;
  assign ID_instruction = if_id.instruction;
  assign ID_valid       = if_id.valid;

endmodule
